// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, prefetches sequentially into a
// DEPTH-entry queue feeding ID, and redirects on trap or jump/branch.
//
// state | meaning
// RUN   | issuing sequential fetch requests while the queue has room
// HALT  | a fetch returned a bus error; wait for a redirect
module if_fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h8000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trap_en_i,
    input  logic [ADDR_W-1:0]       trap_addr_i,
    input  logic                    jb_en_i,
    input  logic [ADDR_W-1:0]       jb_addr_i,
    input  logic                    dont_fetch_i,
    output logic                    if_valid_o,
    output logic [ADDR_W-1:0]       if_addr_o,
    output logic [1:0]              if_size_o,
    output logic                    if_req_o,
    input  logic                    if_ready_i,
    input  logic [DATA_W-1:0]       if_data_read_i,
    input  logic [1:0]              if_resp_i,
    output logic                    fetched_ok_o,
    output logic                    inst_valid_o,
    output logic [31:0]             inst_o,
    output logic [ADDR_W-1:0]       inst_addr_o,
    output logic                    inst_fault_o,
    input  logic                    id_ready_i,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int         PW        = $clog2(DEPTH);
    localparam int         CW        = PW + 1;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic       REQ_READ  = 1'b0;

    typedef enum logic {RUN, HALT} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fpc_q, fpc_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
    logic [ADDR_W-1:0]   addr_mem_d [DEPTH];
    logic [31:0]         inst_mem_q [DEPTH];
    logic [31:0]         inst_mem_d [DEPTH];
    logic [DEPTH-1:0]    fault_mem_q, fault_mem_d;

    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                handshake;
    logic                pop;
    logic                resp_err;
    logic [31:0]         fetch_inst;

    // A 64-bit beat carries two instructions; fpc[2] selects the half.
    generate
        if (DATA_W == 64) begin : g_sel64
            assign fetch_inst = fpc_q[2] ? if_data_read_i[63:32] : if_data_read_i[31:0];
        end else begin : g_sel32
            assign fetch_inst = if_data_read_i[31:0];
        end
    endgenerate

    assign redirect    = trap_en_i | jb_en_i;
    assign redirect_pc = trap_en_i ? trap_addr_i : jb_addr_i;
    assign resp_err    = (if_resp_i != 2'b00);

    // rst gates the request so nothing is issued while reset is held.
    assign if_valid_o   = rst & (state_q == RUN) & ~dont_fetch_i & ~redirect
                          & (count_q != CW'(DEPTH));
    assign handshake    = if_valid_o & if_ready_i;
    assign fetched_ok_o = handshake;
    assign if_addr_o    = fpc_q;
    assign if_size_o    = SIZE_WORD;
    assign if_req_o     = REQ_READ;

    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o & id_ready_i;
    assign inst_o       = inst_mem_q[rd_ptr_q];
    assign inst_addr_o  = addr_mem_q[rd_ptr_q];
    assign inst_fault_o = inst_valid_o & fault_mem_q[rd_ptr_q];
    assign count_o      = count_q;

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_mem_d  = addr_mem_q;
        inst_mem_d  = inst_mem_q;
        fault_mem_d = fault_mem_q;

        if (redirect) begin
            // Any pop this cycle is swallowed by the flush.
            state_d  = RUN;
            fpc_d    = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (handshake) begin
                addr_mem_d[wr_ptr_q]  = fpc_q;
                inst_mem_d[wr_ptr_q]  = fetch_inst;
                fault_mem_d[wr_ptr_q] = resp_err;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                fpc_d                 = fpc_q + ADDR_W'(4);
                if (resp_err) begin
                    state_d = HALT;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({handshake, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            fpc_q    <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: head outputs are qualified by count.
    always_ff @(posedge clk) begin
        addr_mem_q  <= addr_mem_d;
        inst_mem_q  <= inst_mem_d;
        fault_mem_q <= fault_mem_d;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the fetch front end.
module tb_if_fetch_queue;

    localparam int          ADDR_W   = 64;
    localparam int          DATA_W   = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic              clk;
    logic              rst;
    logic              trap_en_i;
    logic [63:0]       trap_addr_i;
    logic              jb_en_i;
    logic [63:0]       jb_addr_i;
    logic              dont_fetch_i;
    logic              if_valid_o;
    logic [63:0]       if_addr_o;
    logic [1:0]        if_size_o;
    logic              if_req_o;
    logic              if_ready_i;
    logic [63:0]       if_data_read_i;
    logic [1:0]        if_resp_i;
    logic              fetched_ok_o;
    logic              inst_valid_o;
    logic [31:0]       inst_o;
    logic [63:0]       inst_addr_o;
    logic              inst_fault_o;
    logic              id_ready_i;
    logic [2:0]        count_o;

    if_fetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .trap_en_i(trap_en_i), .trap_addr_i(trap_addr_i),
        .jb_en_i(jb_en_i), .jb_addr_i(jb_addr_i),
        .dont_fetch_i(dont_fetch_i),
        .if_valid_o(if_valid_o), .if_addr_o(if_addr_o),
        .if_size_o(if_size_o), .if_req_o(if_req_o),
        .if_ready_i(if_ready_i), .if_data_read_i(if_data_read_i), .if_resp_i(if_resp_i),
        .fetched_ok_o(fetched_ok_o),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .inst_fault_o(inst_fault_o), .id_ready_i(id_ready_i), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] i;
        logic        f;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_fpc;
    logic        m_halt;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Applies one cycle of inputs, checks outputs against the model, then
    // advances the model across the clock edge.
    task automatic step(input logic r, input logic t, input logic [63:0] ta,
                        input logic j, input logic [63:0] ja, input logic df,
                        input logic rdy, input logic [63:0] d, input logic [1:0] rs,
                        input logic idr);
        logic  exp_valid;
        logic  hs;
        ent_t  e;
        rst = r; trap_en_i = t; trap_addr_i = ta; jb_en_i = j; jb_addr_i = ja;
        dont_fetch_i = df; if_ready_i = rdy; if_data_read_i = d; if_resp_i = rs;
        id_ready_i = idr;
        #1;
        exp_valid = r && !m_halt && !df && !(t || j) && (mq.size() < DEPTH);
        hs = exp_valid && rdy;
        chk("if_valid", if_valid_o, exp_valid);
        chk("if_addr", if_addr_o, m_fpc);
        chk("fetched_ok", fetched_ok_o, hs);
        chk("inst_valid", inst_valid_o, mq.size() != 0);
        chk("count", count_o, mq.size());
        chk("size_req", {if_size_o, if_req_o}, {2'b10, 1'b0});
        if (mq.size() != 0) begin
            chk("inst", inst_o, mq[0].i);
            chk("inst_addr", inst_addr_o, mq[0].a);
            chk("inst_fault", inst_fault_o, mq[0].f);
        end
        if (!r) begin
            mq.delete();
            m_fpc  = RESET_PC;
            m_halt = 1'b0;
        end else if (t || j) begin
            mq.delete();
            m_fpc  = t ? ta : ja;
            m_halt = 1'b0;
        end else begin
            if (mq.size() != 0 && idr) void'(mq.pop_front());
            if (hs) begin
                e.a = m_fpc;
                e.i = m_fpc[2] ? d[63:32] : d[31:0];
                e.f = (rs != 2'b00);
                mq.push_back(e);
                m_fpc = m_fpc + 64'd4;
                if (rs != 2'b00) m_halt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b0; trap_en_i = 0; trap_addr_i = '0; jb_en_i = 0; jb_addr_i = '0;
        dont_fetch_i = 0; if_ready_i = 0; if_data_read_i = '0; if_resp_i = '0; id_ready_i = 0;
        m_fpc = RESET_PC; m_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_valid", if_valid_o, 1'b0);
        chk("rst_count", count_o, 3'd0);
        chk("rst_inst_valid", inst_valid_o, 1'b0);
        chk("rst_inst_fault", inst_fault_o, 1'b0);
        chk("rst_fetched_ok", fetched_ok_o, 1'b0);
        chk("rst_fpc", if_addr_o, RESET_PC);

        // Streaming at one instruction per cycle.
        for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0, 0, 1, rnd64(), 0, 1);

        // Fill to DEPTH with ID stalled, one pop, then refill.
        for (int k = 0; k < 6; k++) step(1, 0, 0, 0, 0, 0, 1, rnd64(), 0, 0);
        chk("full_count", count_o, 3'd4);
        chk("full_if_valid", if_valid_o, 1'b0);
        step(1, 0, 0, 0, 0, 0, 0, rnd64(), 0, 1);
        chk("pop_count", count_o, 3'd3);
        step(1, 0, 0, 0, 0, 0, 1, rnd64(), 0, 0);
        chk("refill_count", count_o, 3'd4);

        // Simultaneous trap and jump with three entries queued: trap wins.
        step(1, 0, 0, 0, 0, 0, 0, rnd64(), 0, 1);
        chk("pre_redirect_count", count_o, 3'd3);
        step(1, 1, 64'h100, 1, 64'h300, 0, 1, rnd64(), 0, 1);
        chk("redirect_count", count_o, 3'd0);
        chk("redirect_pc", if_addr_o, 64'h100);

        // Bus error on the fetch at 0x8000_0008 halts fetching until a jump.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            step(1, 0, 0, 0, 0, 0, 1, rnd64(), (m_fpc == 64'h8000_0008) ? 2'b10 : 2'b00, 0);
        chk("halt_if_valid", if_valid_o, 1'b0);
        chk("halt_count", count_o, 3'd3);
        step(1, 0, 0, 1, 64'h200, 0, 1, rnd64(), 0, 0);
        chk("resume_pc", if_addr_o, 64'h200);
        step(1, 0, 0, 0, 0, 0, 1, rnd64(), 0, 0);

        // Halfword selection within a 64-bit beat.
        step(1, 0, 0, 1, 64'h1000, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 64'h1111_1111_2222_2222, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 64'h1111_1111_2222_2222, 0, 0);
        chk("lo_word", inst_o, 32'h2222_2222);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("hi_word", inst_o, 32'h1111_1111);

        // dont_fetch drains the queue, then reset mid-stream.
        step(1, 0, 0, 0, 0, 1, 1, rnd64(), 0, 1);
        step(1, 0, 0, 0, 0, 1, 1, rnd64(), 0, 1);
        chk("drain_count", count_o, 3'd0);
        step(1, 0, 0, 0, 0, 0, 1, rnd64(), 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, rnd64(), 0, 0);
        chk("midrst_count", count_o, 3'd0);
        chk("midrst_fpc", if_addr_o, RESET_PC);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(99) < 3), rnd64(),
                 ($urandom_range(99) < 5), rnd64(),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 70), rnd64(),
                 ($urandom_range(99) < 3) ? 2'($urandom_range(3, 1)) : 2'b00,
                 ($urandom_range(99) < 60));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
